// File: rtl/motion_pkg.sv
// Shared definitions for the motion scheduler: channel FSM encoding and default step periods.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package motion_pkg;

  // Per-channel sequencing states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } ch_state_e;

  // Nominal system clock the default periods are derived from
  localparam longint unsigned DEF_CLOCK_FREQUENCY = 64'd50_000_000;

  // Clocks per step: the alien block falls one row every 4 s, a shot rises 3 rows per second
  function automatic longint unsigned alien_fall_period(input longint unsigned clk_hz);
    return clk_hz * 4;
  endfunction

  function automatic longint unsigned shot_rise_period(input longint unsigned clk_hz);
    return clk_hz / 3;
  endfunction

  localparam longint unsigned ALIEN_FALL_PERIOD = alien_fall_period(DEF_CLOCK_FREQUENCY);
  localparam longint unsigned SHOT_RISE_PERIOD  = shot_rise_period(DEF_CLOCK_FREQUENCY);

endpackage

// File: rtl/motion_channel.sv
// One motion channel: steps a position once per period clocks, then waits for the draw path to ack.
// Latency: first step 'period' cycles after start; draw_req visible the cycle after the final divider tick.
// Backpressure: draw_req is held and the channel stalls (pos and divider frozen) until draw_ack.
module motion_channel
  import motion_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int POS_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [CNT_W-1:0] period,
  input  logic [POS_W-1:0] init_pos,
  input  logic [POS_W-1:0] limit,
  input  logic             pause,
  input  logic             draw_ack,
  output logic [POS_W-1:0] pos,
  output logic             draw_req,
  output logic             busy,
  output logic             done
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             draw_req_q, draw_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] start_reload;

  // A zero period behaves like one: a step on every unpaused cycle
  assign start_reload = (period == '0) ? '0 : (period - CNT_W'(1));

  // Next-state logic; stop overrides everything, including a same-cycle start
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    reload_d   = reload_q;
    pos_d      = pos_q;
    limit_d    = limit_q;
    dir_d      = dir_q;
    draw_req_d = draw_req_q;
    busy_d     = busy_q;
    done_d     = done_q;
    if (stop) begin
      state_d    = ST_IDLE;
      draw_req_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_RUN;
            pos_d    = init_pos;
            reload_d = start_reload;
            div_d    = start_reload;
            dir_d    = dir;
            limit_d  = limit;
            busy_d   = 1'b1;
            done_d   = 1'b0;
          end
        end
        ST_RUN: begin
          if (!pause) begin
            if (div_q == '0) begin
              pos_d      = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
              div_d      = reload_q;
              draw_req_d = 1'b1;
              state_d    = ST_WAIT_ACK;
            end else begin
              div_d = div_q - CNT_W'(1);
            end
          end
        end
        ST_WAIT_ACK: begin
          if (draw_ack) begin
            draw_req_d = 1'b0;
            if (pos_q == limit_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          draw_req_d = 1'b0;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  // Channel state register with registered outputs; reset discards any pending request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      reload_q   <= '0;
      pos_q      <= '0;
      limit_q    <= '0;
      dir_q      <= 1'b0;
      draw_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      reload_q   <= reload_d;
      pos_q      <= pos_d;
      limit_q    <= limit_d;
      dir_q      <= dir_d;
      draw_req_q <= draw_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pos      = pos_q;
  assign draw_req = draw_req_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: rtl/motion_scheduler.sv
// Bank of independent motion channels (ch0 alien fall, ch1 shot rise) sharing one clock and pause.
// Latency: per channel, first step 'period' cycles after start.
// Backpressure: each channel stalls on its own draw_req until its draw_ack; channels never interact.
module motion_scheduler
  import motion_pkg::*;
#(
  parameter longint unsigned CLOCK_FREQUENCY = DEF_CLOCK_FREQUENCY,
  parameter int              NUM_CH          = 2,
  parameter int              CNT_W           = 32,
  parameter int              POS_W           = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*POS_W-1:0] init_pos,
  input  logic [NUM_CH*POS_W-1:0] limit,
  input  logic                    pause,
  input  logic [NUM_CH-1:0]       draw_ack,
  output logic [NUM_CH*POS_W-1:0] pos,
  output logic [NUM_CH-1:0]       draw_req,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  // CLOCK_FREQUENCY only feeds the package period helpers for whoever drives 'period';
  // the channels themselves are frequency-agnostic.

  // One channel per lane; the top only slices the packed buses
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    motion_channel #(
      .CNT_W (CNT_W),
      .POS_W (POS_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .start    (start[i]),
      .stop     (stop[i]),
      .dir      (dir[i]),
      .period   (period[i*CNT_W +: CNT_W]),
      .init_pos (init_pos[i*POS_W +: POS_W]),
      .limit    (limit[i*POS_W +: POS_W]),
      .pause    (pause),
      .draw_ack (draw_ack[i]),
      .pos      (pos[i*POS_W +: POS_W]),
      .draw_req (draw_req[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_motion_scheduler.sv
// Directed bench for motion_scheduler: per-cycle vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_motion_scheduler;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int POS_W  = 6;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       dir;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH*POS_W-1:0] init_pos;
  logic [NUM_CH*POS_W-1:0] limit;
  logic                    pause;
  logic [NUM_CH-1:0]       draw_ack;
  logic [NUM_CH*POS_W-1:0] pos;
  logic [NUM_CH-1:0]       draw_req;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  int checks   = 0;
  int failures = 0;

  motion_scheduler #(
    .CLOCK_FREQUENCY (64'd50_000_000),
    .NUM_CH          (NUM_CH),
    .CNT_W           (CNT_W),
    .POS_W           (POS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .period   (period),
    .init_pos (init_pos),
    .limit    (limit),
    .pause    (pause),
    .draw_ack (draw_ack),
    .pos      (pos),
    .draw_req (draw_req),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle record for channel 0: inputs applied before an edge, outputs expected after it
  typedef struct {
    logic             start;
    logic             ack;
    logic [POS_W-1:0] pos;
    logic             req;
    logic             busy;
    logic             done;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled and inputs changed 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [POS_W-1:0] pos_of(input int ch);
    return pos[ch*POS_W +: POS_W];
  endfunction

  task automatic set_ch(input int ch, input int per, input int ip, input int lim, input logic d);
    period[ch*CNT_W +: CNT_W]   = CNT_W'(per);
    init_pos[ch*POS_W +: POS_W] = POS_W'(ip);
    limit[ch*POS_W +: POS_W]    = POS_W'(lim);
    dir[ch]                     = d;
  endtask

  task automatic pulse_start(input int ch);
    start[ch] = 1'b1;
    tick();
    start[ch] = 1'b0;
  endtask

  task automatic pulse_ack(input int ch);
    draw_ack[ch] = 1'b1;
    tick();
    draw_ack[ch] = 1'b0;
  endtask

  // Bounded wait for draw_req; n = edges advanced (0 if already high)
  task automatic wait_req(input int ch, input int max, output int n);
    n = 0;
    while (draw_req[ch] !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    start    = '0;
    stop     = '0;
    draw_ack = '0;
    pause    = 1'b0;
    reset    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int total;
    int bad_gap;
    logic early_done;

    start    = '0;
    stop     = '0;
    dir      = '0;
    period   = '0;
    init_pos = '0;
    limit    = '0;
    pause    = 1'b0;
    draw_ack = '0;
    reset    = 1'b0;

    // Asynchronous reset state, before any clock edge
    #1;
    chk("reset pos", 64'(pos), 64'd0);
    chk("reset draw_req", 64'(draw_req), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    do_reset();

    // Three steps on ch0 with 1-cycle acks; stray ack in RUN and stray start in RUN ignored
    tbl[0]  = '{1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 6'd1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 6'd2, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 6'd2, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 6'd2, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 6'd2, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 6'd3, 1'b0, 1'b0, 1'b1};

    set_ch(0, 4, 0, 3, 1'b0);
    set_ch(1, 4, 9, 20, 1'b0);
    for (int i = 0; i < 17; i++) begin
      start[0]    = tbl[i].start;
      draw_ack[0] = tbl[i].ack;
      tick();
      start[0]    = 1'b0;
      draw_ack[0] = 1'b0;
      chk($sformatf("tbl[%0d] pos", i), 64'(pos_of(0)), 64'(tbl[i].pos));
      chk($sformatf("tbl[%0d] req", i), 64'(draw_req[0]), 64'(tbl[i].req));
      chk($sformatf("tbl[%0d] busy", i), 64'(busy[0]), 64'(tbl[i].busy));
      chk($sformatf("tbl[%0d] done", i), 64'(done[0]), 64'(tbl[i].done));
      chk($sformatf("tbl[%0d] ch1 busy", i), 64'(busy[1]), 64'd0);
    end

    // Decrement with wrap: 0 -> 63 -> 62 = limit, then restart from DONE
    do_reset();
    set_ch(0, 2, 0, 62, 1'b1);
    pulse_start(0);
    wait_req(0, 20, n);
    chk("wrap step1 cycles", 64'(n), 64'd2);
    chk("wrap step1 pos", 64'(pos_of(0)), 64'd63);
    pulse_ack(0);
    chk("wrap mid done", 64'(done[0]), 64'd0);
    wait_req(0, 20, n);
    chk("wrap step2 cycles", 64'(n), 64'd2);
    chk("wrap step2 pos", 64'(pos_of(0)), 64'd62);
    pulse_ack(0);
    chk("wrap done", 64'(done[0]), 64'd1);
    chk("wrap busy", 64'(busy[0]), 64'd0);
    set_ch(0, 2, 10, 12, 1'b0);
    pulse_start(0);
    chk("restart done", 64'(done[0]), 64'd0);
    chk("restart pos", 64'(pos_of(0)), 64'd10);
    chk("restart busy", 64'(busy[0]), 64'd1);

    // Pause for 10 cycles mid-RUN delays the step by exactly 10; withheld ack freezes the channel
    do_reset();
    set_ch(0, 4, 0, 5, 1'b0);
    pulse_start(0);
    tick();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    pause = 1'b0;
    chk("pause no early step", 64'(draw_req[0]), 64'd0);
    wait_req(0, 30, n);
    total = 1 + 10 + n;
    chk("pause step cycles", 64'(total), 64'd14);
    for (int i = 0; i < 20; i++) tick();
    chk("noack pos frozen", 64'(pos_of(0)), 64'd1);
    chk("noack req held", 64'(draw_req[0]), 64'd1);
    pulse_ack(0);
    chk("late ack req clear", 64'(draw_req[0]), 64'd0);

    // ch1 stop+start in RUN goes IDLE with pos held; ch0 keeps its cadence
    do_reset();
    set_ch(0, 4, 0, 10, 1'b0);
    set_ch(1, 3, 5, 20, 1'b0);
    start = 2'b11;
    tick();
    start = 2'b00;
    tick();
    tick();
    tick();
    chk("iso ch1 req", 64'(draw_req[1]), 64'd1);
    chk("iso ch1 pos", 64'(pos_of(1)), 64'd6);
    draw_ack[1] = 1'b1;
    tick();
    draw_ack[1] = 1'b0;
    chk("iso ch0 req edge4", 64'(draw_req[0]), 64'd1);
    draw_ack[0] = 1'b1;
    stop[1]     = 1'b1;
    start[1]    = 1'b1;
    tick();
    draw_ack[0] = 1'b0;
    stop[1]     = 1'b0;
    start[1]    = 1'b0;
    chk("iso ch1 busy", 64'(busy[1]), 64'd0);
    chk("iso ch1 pos held", 64'(pos_of(1)), 64'd6);
    wait_req(0, 20, n);
    chk("iso ch0 next step", 64'(n), 64'd4);
    chk("iso ch0 pos", 64'(pos_of(0)), 64'd2);
    chk("iso ch1 still idle", 64'(busy[1]), 64'd0);
    chk("iso ch1 no move", 64'(pos_of(1)), 64'd6);

    // Async reset mid-handshake clears everything without a clock edge; no motion after release
    do_reset();
    set_ch(0, 2, 4, 30, 1'b0);
    set_ch(1, 2, 7, 30, 1'b0);
    start = 2'b11;
    tick();
    start = 2'b00;
    wait_req(0, 20, n);
    chk("pre-reset req", 64'(draw_req), 64'd3);
    #3;
    reset = 1'b0;
    #1;
    chk("async pos", 64'(pos), 64'd0);
    chk("async draw_req", 64'(draw_req), 64'd0);
    chk("async busy", 64'(busy), 64'd0);
    chk("async done", 64'(done), 64'd0);
    tick();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("post-release req", 64'(draw_req), 64'd0);
    chk("post-release busy", 64'(busy), 64'd0);
    chk("post-release pos", 64'(pos), 64'd0);

    // Period 0, init == limit: one step per cycle, done only after a full wrap (64 steps)
    do_reset();
    set_ch(0, 0, 0, 0, 1'b0);
    pulse_start(0);
    wait_req(0, 5, n);
    chk("p0 first step cycles", 64'(n), 64'd1);
    chk("p0 first pos", 64'(pos_of(0)), 64'd1);
    pulse_ack(0);
    chk("p0 no done after first", 64'(done[0]), 64'd0);
    bad_gap    = 0;
    early_done = 1'b0;
    for (int k = 2; k <= 64; k++) begin
      wait_req(0, 5, n);
      if (n != 1) bad_gap++;
      pulse_ack(0);
      if (k < 64 && done[0]) early_done = 1'b1;
    end
    chk("p0 step gaps", 64'(bad_gap), 64'd0);
    chk("p0 early done", 64'(early_done), 64'd0);
    chk("p0 final pos", 64'(pos_of(0)), 64'd0);
    chk("p0 done", 64'(done[0]), 64'd1);

    // Period 1 behaves the same as period 0
    do_reset();
    set_ch(0, 1, 3, 5, 1'b0);
    pulse_start(0);
    wait_req(0, 5, n);
    chk("p1 step1 cycles", 64'(n), 64'd1);
    chk("p1 step1 pos", 64'(pos_of(0)), 64'd4);
    pulse_ack(0);
    wait_req(0, 5, n);
    chk("p1 step2 cycles", 64'(n), 64'd1);
    chk("p1 step2 pos", 64'(pos_of(0)), 64'd5);
    pulse_ack(0);
    chk("p1 done", 64'(done[0]), 64'd1);
    chk("p1 busy", 64'(busy[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
